// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between two cores.
// Registered ack/rdata/err per core, plus saturating per-core stall counters.
module instr_fetch_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ROM_DEPTH = 128,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  stall_cnt0,
   output logic [CNT_W-1:0]  stall_cnt1
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              last_grant;
   logic              grant0;
   logic              grant1;
   logic              out_of_range;
   logic [DATA_W-1:0] fetch_word;

   // On a tie the core that did not win last time gets the ROM.
   always_comb begin
      grant0   = req0 & (~req1 | last_grant);
      grant1   = req1 & (~req0 | ~last_grant);
      mem_addr = '0;
      if (grant0)
         mem_addr = addr0;
      else if (grant1)
         mem_addr = addr1;
   end

   assign out_of_range = (mem_addr >> 2) >= ADDR_W'(ROM_DEPTH);
   // Out-of-range fetches return a NOP instead of whatever the ROM drives.
   assign fetch_word   = out_of_range ? '0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         stall_cnt0 <= '0;
         stall_cnt1 <= '0;
      end else begin
         ack0 <= grant0;
         ack1 <= grant1;
         if (grant0) begin
            rdata0     <= fetch_word;
            err0       <= out_of_range;
            last_grant <= 1'b0;
         end
         if (grant1) begin
            rdata1     <= fetch_word;
            err1       <= out_of_range;
            last_grant <= 1'b1;
         end
         if (req0 && !grant0 && stall_cnt0 != CNT_MAX)
            stall_cnt0 <= stall_cnt0 + CNT_W'(1);
         if (req1 && !grant1 && stall_cnt1 != CNT_MAX)
            stall_cnt1 <= stall_cnt1 + CNT_W'(1);
      end
   end

endmodule

// File: doc/instr_fetch_arbiter.md
# instr_fetch_arbiter

Two-port round-robin arbiter that shares the single combinational instruction ROM (128 words, word-addressed by byte address >> 2) between core 0 and core 1 of the dual-core processor. Each cycle it grants at most one fetch, drives the granted address to the ROM, and returns the registered instruction word with a one-cycle acknowledge to the winning core. It also flags out-of-range fetches and keeps per-core stall counters for performance debug.

## Interface
- ADDR_W, 32, fetch address width (byte address)
- DATA_W, 32, instruction width
- ROM_DEPTH, 128, ROM words; valid word index 0..ROM_DEPTH-1
- CNT_W, 16, stall counter width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  fetch request from core 0 / core 1
- addr0 / addr1  in  ADDR_W  byte fetch address; held stable while req is high until ack
- ack0 / ack1  out  1  registered; high for one cycle when rdata is valid for that core
- rdata0 / rdata1  out  DATA_W  registered instruction word for that core
- err0 / err1  out  1  registered with ack; fetch was out of range
- mem_addr  out  ADDR_W  combinational address to ROM (granted core's addr)
- mem_rdata  in  DATA_W  combinational ROM read data
- stall_cnt0 / stall_cnt1  out  CNT_W  saturating count of cycles the core requested but was not granted

## Operation
- State: last_grant (1 bit), ack/rdata/err registers, two stall counters.
- Grant (combinational, per cycle): only req0 -> core 0; only req1 -> core 1; both -> core opposite to last_grant; neither -> no grant, mem_addr = 0.
- A core already acked this cycle (ackX=1) and still requesting is a new request; no special handling.
- On clock edge with grant to core X: rdataX <= mem_rdata, ackX <= 1, errX <= range check, last_grant <= X. Other core's ack <= 0, its rdata holds.
- Range check: word index = addrX >> 2; if index >= ROM_DEPTH then errX <= 1 and rdataX <= 32'h0000_0000 (NOP, sll $0,$0,0) instead of mem_rdata. Low two address bits ignored.
- No grant: ack0 = ack1 = 0; rdata/err hold.
- Stall counter X increments by 1 each cycle reqX=1 and X not granted; saturates at 2^CNT_W-1; never decrements; cleared only by reset.

## Timing
- Latency: request presented in cycle N and granted -> ack + rdata in cycle N+1.
- Single requester held high: ack every cycle, throughput 1 fetch/cycle.
- Both held high: alternate grants; each core acked every 2nd cycle; each stall counter +1 per 2 cycles.
- Reset values: ack0 = ack1 = 0, rdata0 = rdata1 = 0, err0 = err1 = 0, stall counters = 0, last_grant = 1 (core 0 wins the first tie).
- Reset asserted in the same cycle as a grant: reset wins; no ack next cycle, last_grant = 1.
- Req dropped before grant: request abandoned, no ack, no counter change that cycle.
- Core changing addr while req high and not yet granted: the address present in the grant cycle is fetched.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; mem_addr = 0.
- req0 only, addr0 = 0x0000_0008, ROM[2] = 0x2010_0001: ack0 = 1 next cycle with rdata0 = 0x2010_0001, err0 = 0, ack1 = 0; hold req 4 cycles -> 4 consecutive acks.
- req0 and req1 both from cycle 0 (addr0 = 0x0, addr1 = 0x4): acks order core0, core1, core0, core1; stall_cnt0 = stall_cnt1 = 2 after 4 grant cycles.
- Out of range: req1 with addr1 = 0x0000_0200 (index 128): ack1 = 1, err1 = 1, rdata1 = 0x0; following in-range fetch clears err1.
- Saturation: with CNT_W = 4, hold req1 while core 0 continuously requests for 40 cycles: stall_cnt1 stops at 15.
- Reset mid-contention: both requesting, assert reset one cycle -> next cycle all acks 0, counters 0; after release core 0 granted first.
